crossy_robbers_soc_pulse_pio: RTL and testbench

Parametrised Avalon-MM output PIO with atomic set/clear access and a hardware-timed pulse generator. It sits on the SoC's lightweight slave bus and drives board-level control lines such as the USB chip reset and peripheral enables. Firmware can request a reset pulse of exact length without busy-waiting. It replaces the single-bit level-only output ports.

---
 rtl/crossy_robbers_soc_pulse_pio.sv | 112 +++++++++++
 tb/tb_crossy_robbers_soc_pulse_pio.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/crossy_robbers_soc_pulse_pio.sv
// Avalon-MM output PIO with atomic SET/CLEAR access and a
// hardware-timed pulse engine that ORs a mask onto the outputs.
module crossy_robbers_soc_pulse_pio #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int unsigned      CNT_W         = 16,
  parameter int unsigned      PULSE_DEFAULT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nx;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_mask_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_len_nx;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [CNT_W-1:0] w_wd_len;
  logic [CNT_W-1:0] w_load;
  logic             w_pulse_wr;
  logic             w_busy;
  logic             w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[WIDTH-1:0];
  assign w_wd_len   = writedata[CNT_W-1:0];
  assign w_unused   = ^writedata;
  assign w_busy     = (r_state == S_ACTIVE);
  // A zero length still yields a single-cycle pulse.
  assign w_load     = (r_len == '0) ? CNT_W'(1) : r_len;
  assign w_pulse_wr = w_wr && (address == 3'd3) && (|w_wd);

  always_comb begin
    w_state_nx = r_state;
    w_data_nx  = r_data;
    w_mask_nx  = r_mask;
    w_cnt_nx   = r_cnt;
    w_len_nx   = r_len;
    if (w_wr) begin
      case (address)
        3'd0:    w_data_nx = w_wd;
        3'd1:    w_data_nx = r_data | w_wd;
        3'd2:    w_data_nx = r_data & ~w_wd;
        3'd4:    w_len_nx  = w_wd_len;
        default: ;
      endcase
    end
    // A retrigger beats both the decrement and the terminal clear.
    if (w_pulse_wr) begin
      w_state_nx = S_ACTIVE;
      w_mask_nx  = r_mask | w_wd;
      w_cnt_nx   = w_load;
    end else if (r_state == S_ACTIVE) begin
      if (r_cnt == CNT_W'(1)) begin
        w_state_nx = S_IDLE;
        w_mask_nx  = '0;
        w_cnt_nx   = '0;
      end else begin
        w_cnt_nx = r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= RESET_VALUE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_len   <= CNT_W'(PULSE_DEFAULT);
    end else begin
      r_state <= w_state_nx;
      r_data  <= w_data_nx;
      r_mask  <= w_mask_nx;
      r_cnt   <= w_cnt_nx;
      r_len   <= w_len_nx;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0, 3'd1, 3'd2: readdata[WIDTH-1:0] = r_data;
      3'd3:             readdata[WIDTH-1:0] = r_mask;
      3'd4:             readdata[CNT_W-1:0] = r_len;
      3'd5:             readdata[0]         = w_busy;
      default:          readdata            = '0;
    endcase
  end

  assign out_port = r_data | (w_busy ? r_mask : '0);

endmodule

// File: tb/tb_crossy_robbers_soc_pulse_pio.sv
// Directed bench: expected values queued at stimulus time,
// popped and compared against the DUT when observed.
module tb_crossy_robbers_soc_pulse_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic [31:0] readdata1;
  logic [0:0]  out1;

  always #5 clk = ~clk;

  crossy_robbers_soc_pulse_pio #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .CNT_W(16), .PULSE_DEFAULT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  crossy_robbers_soc_pulse_pio #(
    .WIDTH(1), .RESET_VALUE(1'b0), .CNT_W(16), .PULSE_DEFAULT(16)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata1),
    .out_port(out1)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic outchk(input string tag, input logic [7:0] v);
    push(tag, 32'(v));
    pop_chk(32'(out_port));
  endtask

  task automatic rdchk(input logic [2:0] a, input string tag,
                       input logic [31:0] v);
    push(tag, v);
    address = a;
    #1;
    pop_chk(readdata);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    step();
    step();
    reset_n = 1'b1;

    outchk("rst_out", 8'hA5);
    rdchk(3'd5, "rst_status", 32'h0);
    rdchk(3'd4, "rst_len", 32'd16);
    rdchk(3'd3, "rst_mask", 32'h0);
    push("rst_out1", 32'h0);
    pop_chk(32'(out1));

    wr(3'd0, 32'h3C);
    outchk("data_wr", 8'h3C);
    rdchk(3'd0, "data_rd", 32'h3C);

    wr(3'd0, 32'h0F);
    wr(3'd1, 32'hF0);
    outchk("set", 8'hFF);
    wr(3'd2, 32'h81);
    outchk("clear", 8'h7E);
    rdchk(3'd0, "rd_a0", 32'h7E);
    rdchk(3'd1, "rd_a1", 32'h7E);
    rdchk(3'd2, "rd_a2", 32'h7E);

    wr(3'd0, 32'h0);
    wr(3'd4, 32'hFFFF_0005);
    rdchk(3'd4, "len_trunc", 32'd5);
    wr(3'd3, 32'h0);
    rdchk(3'd5, "zero_pulse_busy", 32'h0);
    outchk("zero_pulse_out", 8'h00);

    wr(3'd3, 32'h01);
    address = 3'd5;
    for (int i = 0; i < 5; i++) begin
      push("p5_out", 32'h01);
      push("p5_busy", 32'h1);
    end
    for (int i = 0; i < 5; i++) begin
      pop_chk(32'(out_port));
      pop_chk(readdata);
      step();
    end
    outchk("p5_end_out", 8'h00);
    rdchk(3'd5, "p5_end_busy", 32'h0);
    rdchk(3'd3, "p5_end_mask", 32'h0);

    wr(3'd4, 32'h0);
    rdchk(3'd4, "len0_rd", 32'h0);
    wr(3'd3, 32'h01);
    outchk("len0_on", 8'h01);
    step();
    outchk("len0_off", 8'h00);

    wr(3'd4, 32'd5);
    wr(3'd3, 32'h01);
    outchk("rt_c0", 8'h01);
    step();
    outchk("rt_c1", 8'h01);
    step();
    outchk("rt_c2", 8'h01);
    wr(3'd3, 32'h02);
    outchk("rt_c3", 8'h03);
    for (int i = 0; i < 4; i++) begin
      push("rt_ext", 32'h03);
      step();
      pop_chk(32'(out_port));
    end
    step();
    outchk("rt_c8", 8'h00);

    wr(3'd4, 32'd10);
    wr(3'd0, 32'h01);
    wr(3'd3, 32'h01);
    step();
    wr(3'd2, 32'h01);
    outchk("clr_hold", 8'h01);
    rdchk(3'd0, "clr_data", 32'h0);
    for (int i = 0; i < 7; i++) begin
      push("clr_pulse", 32'h01);
      step();
      pop_chk(32'(out_port));
    end
    step();
    outchk("clr_end", 8'h00);

    wr(3'd3, 32'h01);
    step();
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    outchk("midrst_out", 8'hA5);
    rdchk(3'd5, "midrst_busy", 32'h0);
    rdchk(3'd3, "midrst_mask", 32'h0);
    rdchk(3'd4, "midrst_len", 32'd16);

    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    outchk("a6_out", 8'hA5);
    rdchk(3'd6, "a6_rd", 32'h0);
    rdchk(3'd7, "a7_rd", 32'h0);
    rdchk(3'd0, "a6_data", 32'hA5);
    rdchk(3'd5, "a5_wr_ign", 32'h0);

    wr(3'd0, 32'hFFFF_FFFE);
    outchk("w8_trunc", 8'hFE);
    push("w1_out", 32'h0);
    pop_chk(32'(out1));
    address = 3'd0;
    #1;
    push("w1_rd", 32'h0);
    pop_chk(readdata1);
    wr(3'd1, 32'h1);
    push("w1_set", 32'h1);
    pop_chk(32'(out1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
